// File: rtl/systolic_seq_ctrl_if.sv
// rtl/systolic_seq_ctrl_if.sv - control, operand-buffer and lane bundle for the systolic sequencer
interface systolic_seq_ctrl_if #(
    parameter int N  = 2,
    parameter int DW = 8,
    parameter int AW = 4
);
    logic            start;
    logic            abort;
    logic [AW:0]     k_len;
    logic            busy;
    logic            done;
    logic            array_clr;
    logic            capture;
    logic            a_rd_en;
    logic            b_rd_en;
    logic [AW-1:0]   a_addr;
    logic [AW-1:0]   b_addr;
    logic [N*DW-1:0] a_rd_data;
    logic [N*DW-1:0] b_rd_data;
    logic [N*DW-1:0] a_lane;
    logic [N*DW-1:0] b_lane;

    modport master (
        output start, abort, k_len, a_rd_data, b_rd_data,
        input  busy, done, array_clr, capture, a_rd_en, b_rd_en,
        input  a_addr, b_addr, a_lane, b_lane
    );

    modport slave (
        input  start, abort, k_len, a_rd_data, b_rd_data,
        output busy, done, array_clr, capture, a_rd_en, b_rd_en,
        output a_addr, b_addr, a_lane, b_lane
    );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// rtl/systolic_seq_ctrl.sv - pass sequencer and operand skew network for an NxN systolic array
module systolic_seq_ctrl #(
    parameter int N  = 2,
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic                clk,
    input  logic                rst,
    systolic_seq_ctrl_if.slave  bus
);
    // One counter serves both FEED (up to 2^AW) and DRAIN (2N) phases.
    localparam int CW = ((AW + 1) > ($clog2(2 * N) + 1)) ? (AW + 1) : ($clog2(2 * N) + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state;
    logic [AW:0]   k_q;
    logic [CW-1:0] cnt;
    logic          busy_q;
    logic          done_q;
    logic          capture_q;
    logic          clr_q;
    logic          rd_en_q;
    logic [AW-1:0] addr_q;
    logic          rd_vld;
    logic          flush;

    assign flush = rst || (bus.abort && busy_q);

    always_ff @(posedge clk) begin
        if (flush) begin
            state     <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            capture_q <= 1'b0;
            clr_q     <= 1'b0;
            rd_en_q   <= 1'b0;
            addr_q    <= '0;
            cnt       <= '0;
            if (rst) k_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        k_q    <= bus.k_len;
                        state  <= S_CLEAR;
                        busy_q <= 1'b1;
                        clr_q  <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    clr_q <= 1'b0;
                    cnt   <= '0;
                    if (k_q != '0) begin
                        state   <= S_FEED;
                        rd_en_q <= 1'b1;
                        addr_q  <= '0;
                    end else begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                    end
                end
                S_FEED: begin
                    if (cnt == CW'(k_q) - CW'(1)) begin
                        state   <= S_DRAIN;
                        rd_en_q <= 1'b0;
                        addr_q  <= '0;
                        cnt     <= '0;
                    end else begin
                        cnt    <= cnt + 1'b1;
                        addr_q <= addr_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (cnt == CW'(2 * N - 1)) begin
                        state     <= S_DONE;
                        done_q    <= 1'b1;
                        capture_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    capture_q <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Read data is only trusted in the cycle right after a strobe.
    always_ff @(posedge clk) begin
        if (flush) rd_vld <= 1'b0;
        else       rd_vld <= rd_en_q;
    end

    // Lane i: capture slot plus i skew stages; the oldest slot drives the array edge.
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        logic [(gi+1)*DW-1:0] a_pipe;
        logic [(gi+1)*DW-1:0] b_pipe;
        logic [DW-1:0]        a_in;
        logic [DW-1:0]        b_in;

        assign a_in = rd_vld ? bus.a_rd_data[gi*DW +: DW] : '0;
        assign b_in = rd_vld ? bus.b_rd_data[gi*DW +: DW] : '0;

        always_ff @(posedge clk) begin
            if (flush) begin
                a_pipe <= '0;
                b_pipe <= '0;
            end else begin
                a_pipe <= (a_pipe << DW) | ((gi+1)*DW)'(a_in);
                b_pipe <= (b_pipe << DW) | ((gi+1)*DW)'(b_in);
            end
        end

        assign bus.a_lane[gi*DW +: DW] = a_pipe[(gi+1)*DW-1 -: DW];
        assign bus.b_lane[gi*DW +: DW] = b_pipe[(gi+1)*DW-1 -: DW];
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.capture   = capture_q;
    assign bus.array_clr = clr_q;
    assign bus.a_rd_en   = rd_en_q;
    assign bus.b_rd_en   = rd_en_q;
    assign bus.a_addr    = addr_q;
    assign bus.b_addr    = addr_q;
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb/tb_systolic_seq_ctrl.sv - randomized self-checking bench for systolic_seq_ctrl
module tb_systolic_seq_ctrl;
    localparam int N  = 2;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int NO_ABORT = 100000;

    typedef struct packed {
        logic            busy;
        logic            done;
        logic            clr;
        logic            cap;
        logic            a_en;
        logic            b_en;
        logic [AW-1:0]   a_addr;
        logic [AW-1:0]   b_addr;
        logic [N*DW-1:0] a_lane;
        logic [N*DW-1:0] b_lane;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    obs_t obs;
    obs_t e;
    logic [N*DW-1:0] a_mem [2**AW];
    logic [N*DW-1:0] b_mem [2**AW];

    systolic_seq_ctrl_if #(.N(N), .DW(DW), .AW(AW)) bus ();

    systolic_seq_ctrl #(.N(N), .DW(DW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Operand buffers: one-cycle read latency, garbage on the bus when not strobed.
    always @(posedge clk) begin
        bus.a_rd_data <= bus.a_rd_en ? a_mem[bus.a_addr] : (N*DW)'($urandom);
        bus.b_rd_data <= bus.b_rd_en ? b_mem[bus.b_addr] : (N*DW)'($urandom);
    end

    // Expected outputs c cycles after the start sample of a pass of length k,
    // with the pass killed (abort or reset) at cycle ab.
    function automatic obs_t exp_at(input int k, input int c, input int ab);
        obs_t r;
        int   last;
        int   j;
        r = '0;
        if (c > ab) return r;
        last   = (k == 0) ? 2 : 2 * N + k + 2;
        r.busy = (c >= 1) && (c <= last);
        r.clr  = (c == 1);
        r.done = (c == last);
        r.cap  = (c == last) && (k > 0);
        if (k > 0 && c >= 2 && c <= k + 1) begin
            r.a_en   = 1'b1;
            r.b_en   = 1'b1;
            r.a_addr = AW'(c - 2);
            r.b_addr = AW'(c - 2);
        end
        for (int i = 0; i < N; i++) begin
            j = c - 4 - i;
            if (j >= 0 && j < k) begin
                r.a_lane[i*DW +: DW] = a_mem[j][i*DW +: DW];
                r.b_lane[i*DW +: DW] = b_mem[j][i*DW +: DW];
            end
        end
        return r;
    endfunction

    task automatic fill_mem();
        for (int j = 0; j < 2**AW; j++) begin
            a_mem[j] = (N*DW)'($urandom);
            b_mem[j] = (N*DW)'($urandom);
        end
    endtask

    // Drive one cycle of inputs and capture the outputs of that cycle.
    task automatic step(input logic st, input logic ab, input logic rs, input int kv);
        bus.start = st;
        bus.abort = ab;
        rst       = rs;
        bus.k_len = (AW+1)'(kv);
        @(negedge clk);
        obs = {bus.busy, bus.done, bus.array_clr, bus.capture, bus.a_rd_en, bus.b_rd_en,
               bus.a_addr, bus.b_addr, bus.a_lane, bus.b_lane};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b1, 5);
        step(1'b0, 1'b0, 1'b1, 5);
        step(1'b0, 1'b0, 1'b0, 5);
        total++;
        if (obs !== obs_t'(0)) begin
            bad++;
            $display("FAIL reset got=%h exp=%h", obs, obs_t'(0));
        end
    endtask

    task automatic test_basic();
        fill_mem();
        a_mem[0] = 16'h0201;
        a_mem[1] = 16'h0403;
        a_mem[2] = 16'h0605;
        step(1'b1, 1'b0, 1'b0, 3);
        for (int c = 1; c <= 11; c++) begin
            step(1'b0, 1'b0, 1'b0, $urandom_range(0, 16));
            e = exp_at(3, c, NO_ABORT);
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL basic c=%0d got=%h exp=%h", c, obs, e);
            end
        end
    endtask

    task automatic test_k0();
        fill_mem();
        step(1'b1, 1'b0, 1'b0, 0);
        for (int c = 1; c <= 4; c++) begin
            step(1'b0, 1'b0, 1'b0, $urandom_range(1, 16));
            e = exp_at(0, c, NO_ABORT);
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL k0 c=%0d got=%h exp=%h", c, obs, e);
            end
        end
    endtask

    task automatic test_kmax();
        fill_mem();
        step(1'b1, 1'b0, 1'b0, 16);
        for (int c = 1; c <= 24; c++) begin
            step(1'b0, 1'b0, 1'b0, $urandom_range(0, 16));
            e = exp_at(16, c, NO_ABORT);
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL kmax c=%0d got=%h exp=%h", c, obs, e);
            end
        end
    endtask

    task automatic test_ignored_start();
        fill_mem();
        step(1'b1, 1'b0, 1'b0, 3);
        for (int c = 1; c <= 12; c++) begin
            step(c == 4, 1'b0, 1'b0, 7);
            e = exp_at(3, c, NO_ABORT);
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL ignored_start c=%0d got=%h exp=%h", c, obs, e);
            end
        end
    endtask

    task automatic test_abort();
        fill_mem();
        step(1'b1, 1'b0, 1'b0, 3);
        for (int c = 1; c <= 11; c++) begin
            step(1'b0, c == 3, 1'b0, 3);
            e = exp_at(3, c, 3);
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL abort c=%0d got=%h exp=%h", c, obs, e);
            end
        end
    endtask

    task automatic test_abort_idle();
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 1'b1, 1'b0, 4);
            total++;
            if (obs !== obs_t'(0)) begin
                bad++;
                $display("FAIL abort_idle c=%0d got=%h exp=%h", c, obs, obs_t'(0));
            end
        end
    endtask

    task automatic test_reset_mid();
        fill_mem();
        step(1'b1, 1'b0, 1'b0, 3);
        for (int c = 1; c <= 7; c++) begin
            step(1'b0, 1'b0, c == 6, 3);
            e = exp_at(3, c, 6);
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL reset_mid c=%0d got=%h exp=%h", c, obs, e);
            end
        end
        step(1'b1, 1'b0, 1'b0, 3);
        for (int c = 1; c <= 11; c++) begin
            step(1'b0, 1'b0, 1'b0, 9);
            e = exp_at(3, c, NO_ABORT);
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL reset_mid_restart c=%0d got=%h exp=%h", c, obs, e);
            end
        end
    endtask

    task automatic test_random();
        int k;
        int ab;
        int last;
        int lim;
        for (int p = 0; p < 25; p++) begin
            fill_mem();
            k    = $urandom_range(0, 2**AW);
            last = (k == 0) ? 2 : 2 * N + k + 2;
            ab   = ($urandom_range(0, 1) == 1) ? NO_ABORT : $urandom_range(1, last);
            lim  = (ab < last) ? ab : last;
            step(1'b1, 1'(($urandom_range(0, 1))), 1'b0, k);
            for (int c = 1; c <= last + 2; c++) begin
                step((c <= lim) && ($urandom_range(0, 3) == 0), c == ab, 1'b0,
                     $urandom_range(0, 16));
                e = exp_at(k, c, ab);
                total++;
                if (obs !== e) begin
                    bad++;
                    $display("FAIL random p=%0d k=%0d ab=%0d c=%0d got=%h exp=%h",
                             p, k, ab, c, obs, e);
                end
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.k_len = '0;
        rst       = 1'b1;
        fill_mem();
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_k0();
        test_kmax();
        test_ignored_start();
        test_abort();
        test_abort_idle();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
